ins_fetch_unit: RTL

//  Read-side client of the instruction RAM: generates the RAM read address, absorbs its

---
 rtl/ins_fetch_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ins_fetch_unit.sv
// Instruction fetch unit: drives the instruction RAM read address, absorbs the RAM's
// one-edge read latency and presents a valid/ready instruction stream to the core.

module ins_fetch_unit_checker #(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input logic                  clk,
  input logic                  rstN,
  input logic                  active,
  input logic                  jump,
  input logic [ADDR_WIDTH-1:0] jump_addr
);

  // A jump that will be taken must target an address inside the RAM.
  jump_in_range_a : assert property (
    @(posedge clk) disable iff (!rstN)
    (active && jump) |-> ({1'b0, jump_addr} < (ADDR_WIDTH + 1)'(DEPTH))
  ) else $error("jump_addr outside instruction RAM");

endmodule

module ins_fetch_unit #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int START_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [WIDTH-1:0]      ram_data,
  output logic                  ins_valid,
  input  logic                  ins_ready,
  output logic [WIDTH-1:0]      ins_out,
  output logic [ADDR_WIDTH-1:0] ins_pc,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] START_PC = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_PC  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_r, state_s;
  logic [ADDR_WIDTH-1:0] req_pc_r, req_pc_s;
  logic [ADDR_WIDTH-1:0] resp_pc_r, resp_pc_s;
  logic                  resp_valid_r, resp_valid_s;
  logic                  stall_s;

  // Explicit compare so DEPTH need not be a power of two.
  function automatic logic [ADDR_WIDTH-1:0] next_pc(input logic [ADDR_WIDTH-1:0] pc);
    if (pc == LAST_PC) begin
      return '0;
    end else begin
      return pc + ADDR_WIDTH'(1);
    end
  endfunction

  assign stall_s = resp_valid_r & ~ins_ready;
  // While stalled, re-present the held address so ram_data keeps matching ins_pc.
  assign ram_addr  = stall_s ? resp_pc_r : req_pc_r;
  assign ins_out   = ram_data;
  assign ins_pc    = resp_pc_r;
  assign ins_valid = resp_valid_r;
  assign busy      = (state_r == ST_RUN);

  // State and fetch pointer registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_r      <= ST_IDLE;
      req_pc_r     <= START_PC;
      resp_pc_r    <= '0;
      resp_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      req_pc_r     <= req_pc_s;
      resp_pc_r    <= resp_pc_s;
      resp_valid_r <= resp_valid_s;
    end
  end

  // Next-state logic; in RUN halt outranks jump, which outranks advancing.
  always_comb begin
    state_s      = state_r;
    req_pc_s     = req_pc_r;
    resp_pc_s    = resp_pc_r;
    resp_valid_s = resp_valid_r;
    case (state_r)
      ST_IDLE: begin
        resp_valid_s = 1'b0;
        if (start) begin
          state_s  = ST_RUN;
          req_pc_s = START_PC;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (halt) begin
          if (!stall_s) begin
            resp_valid_s = 1'b0;
            state_s      = ST_IDLE;
          end else begin
            state_s      = ST_RUN;
          end
        end else if (jump) begin
          req_pc_s     = jump_addr;
          resp_valid_s = 1'b0;
        end else if (!stall_s) begin
          resp_pc_s    = req_pc_r;
          resp_valid_s = 1'b1;
          req_pc_s     = next_pc(req_pc_r);
        end else begin
          resp_valid_s = resp_valid_r;
        end
      end
      default: begin
        state_s      = ST_IDLE;
        req_pc_s     = START_PC;
        resp_pc_s    = '0;
        resp_valid_s = 1'b0;
      end
    endcase
  end

  ins_fetch_unit_checker #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_checker (
    .clk       (clk),
    .rstN      (rstN),
    .active    (busy & ~halt),
    .jump      (jump),
    .jump_addr (jump_addr)
  );

endmodule
